// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges load and ALU results onto one register-file write port,
// buffering ALU results in a 2-entry age-ordered FIFO. Define WB_OUTREG_EN to register the write port.
module writeback_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_wr_valid,
  input  logic [4:0]  alu_wr_addr,
  input  logic [31:0] alu_data_out,
  input  logic        mem_wr_valid,
  input  logic [4:0]  mem_wr_addr,
  input  logic [31:0] mem_data_out,
  output logic        stall_flag_ex_out,
  output logic        reg_write,
  output logic [4:0]  reg_wr_addr_wb,
  output logic [31:0] reg_wr_data,
  output logic [1:0]  wb_pending
);

  // FIFO is kept compacted: valid entries form a prefix, slot 0 is always the oldest.
  logic [1:0]       valid_q, valid_d;
  logic [1:0][4:0]  addr_q, addr_d;
  logic [1:0][31:0] data_q, data_d;

  logic        memKill, aluAccept, drain, bypass, enq, keep0, keep1;
  logic [1:0]  alive;
  logic        selValid, wrEn;
  logic [4:0]  selAddr;
  logic [31:0] selData;

  assign wb_pending        = {1'b0, valid_q[0]} + {1'b0, valid_q[1]};
  assign stall_flag_ex_out = (valid_q == 2'b11);

  always_comb begin
    memKill   = mem_wr_valid && (mem_wr_addr != 5'd0);
    alive[0]  = valid_q[0] && !(memKill && (addr_q[0] == mem_wr_addr));
    alive[1]  = valid_q[1] && !(memKill && (addr_q[1] == mem_wr_addr));
    aluAccept = alu_wr_valid && !stall_flag_ex_out;

    selValid = 1'b0;
    selAddr  = 5'd0;
    selData  = 32'd0;
    drain    = 1'b0;
    bypass   = 1'b0;
    if (mem_wr_valid) begin
      selValid = 1'b1;
      selAddr  = mem_wr_addr;
      selData  = mem_data_out;
    end else if (valid_q[0]) begin
      selValid = 1'b1;
      selAddr  = addr_q[0];
      selData  = data_q[0];
      drain    = 1'b1;
    end else if (aluAccept) begin
      selValid = 1'b1;
      selAddr  = alu_wr_addr;
      selData  = alu_data_out;
      bypass   = 1'b1;
    end
    wrEn = selValid && (selAddr != 5'd0);

    // Writes to r0 are architecturally dead, so they never occupy a slot.
    enq   = aluAccept && !bypass && (alu_wr_addr != 5'd0);
    keep0 = alive[0] && !drain;
    keep1 = alive[1];

    valid_d = 2'b00;
    addr_d  = '0;
    data_d  = '0;
    if (keep0) begin
      valid_d[0] = 1'b1;
      addr_d[0]  = addr_q[0];
      data_d[0]  = data_q[0];
      if (keep1) begin
        valid_d[1] = 1'b1;
        addr_d[1]  = addr_q[1];
        data_d[1]  = data_q[1];
      end else if (enq) begin
        valid_d[1] = 1'b1;
        addr_d[1]  = alu_wr_addr;
        data_d[1]  = alu_data_out;
      end
    end else if (keep1) begin
      valid_d[0] = 1'b1;
      addr_d[0]  = addr_q[1];
      data_d[0]  = data_q[1];
      if (enq) begin
        valid_d[1] = 1'b1;
        addr_d[1]  = alu_wr_addr;
        data_d[1]  = alu_data_out;
      end
    end else if (enq) begin
      valid_d[0] = 1'b1;
      addr_d[0]  = alu_wr_addr;
      data_d[0]  = alu_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef WB_OUTREG_EN
  logic        regWrite_q;
  logic [4:0]  regAddr_q;
  logic [31:0] regData_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite_q <= 1'b0;
      regAddr_q  <= 5'd0;
      regData_q  <= 32'd0;
    end else begin
      regWrite_q <= wrEn;
      regAddr_q  <= wrEn ? selAddr : 5'd0;
      regData_q  <= wrEn ? selData : 32'd0;
    end
  end

  // Reset also masks the registered port so nothing leaks out during the reset cycle.
  assign reg_write      = regWrite_q && !reset;
  assign reg_wr_addr_wb = reset ? 5'd0  : regAddr_q;
  assign reg_wr_data    = reset ? 32'd0 : regData_q;
`else
  assign reg_write      = wrEn && !reset;
  assign reg_wr_addr_wb = (wrEn && !reset) ? selAddr : 5'd0;
  assign reg_wr_data    = (wrEn && !reset) ? selData : 32'd0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the arbitration rules.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_wr_valid, mem_wr_valid;
  logic [4:0]  alu_wr_addr, mem_wr_addr;
  logic [31:0] alu_data_out, mem_data_out;
  logic        stall_flag_ex_out, reg_write;
  logic [4:0]  reg_wr_addr_wb;
  logic [31:0] reg_wr_data;
  logic [1:0]  wb_pending;

  int checks = 0;
  int errors = 0;

  // Model state: pending ALU results, oldest first, as {addr, data}.
  logic [36:0] modelQ[$];
  logic        outRegW = 1'b0;
  logic [4:0]  outRegA = 5'd0;
  logic [31:0] outRegD = 32'd0;

  writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_wr_valid(alu_wr_valid), .alu_wr_addr(alu_wr_addr), .alu_data_out(alu_data_out),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_data_out(mem_data_out),
    .stall_flag_ex_out(stall_flag_ex_out), .reg_write(reg_write),
    .reg_wr_addr_wb(reg_wr_addr_wb), .reg_wr_data(reg_wr_data), .wb_pending(wb_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md, input bit doCheck);
    logic        selV, accept, bypass, expW;
    logic [4:0]  selA, expA;
    logic [31:0] selD, expD;
    logic [36:0] kept[$];
    @(negedge clk);
    reset = rst; alu_wr_valid = av; alu_wr_addr = aa; alu_data_out = ad;
    mem_wr_valid = mv; mem_wr_addr = ma; mem_data_out = md;
    #1;
    accept = av && (modelQ.size() < 2);
    selV = 1'b0; selA = 5'd0; selD = 32'd0; bypass = 1'b0;
    if (mv) begin
      selV = 1'b1; selA = ma; selD = md;
    end else if (modelQ.size() > 0) begin
      selV = 1'b1; selA = modelQ[0][36:32]; selD = modelQ[0][31:0];
    end else if (accept) begin
      selV = 1'b1; selA = aa; selD = ad; bypass = 1'b1;
    end
    if (selV && selA != 5'd0) begin
      expW = 1'b1; expA = selA; expD = selD;
    end else begin
      expW = 1'b0; expA = 5'd0; expD = 32'd0;
    end
    if (doCheck) begin
      checkOutput("wb_pending", 32'(wb_pending), 32'(modelQ.size()));
      checkOutput("stall", 32'(stall_flag_ex_out), 32'(modelQ.size() == 2));
`ifdef WB_OUTREG_EN
      checkOutput("reg_write", 32'(reg_write), rst ? 32'd0 : 32'(outRegW));
      checkOutput("wr_addr", 32'(reg_wr_addr_wb), rst ? 32'd0 : 32'(outRegA));
      checkOutput("wr_data", reg_wr_data, rst ? 32'd0 : outRegD);
`else
      checkOutput("reg_write", 32'(reg_write), rst ? 32'd0 : 32'(expW));
      checkOutput("wr_addr", 32'(reg_wr_addr_wb), rst ? 32'd0 : 32'(expA));
      checkOutput("wr_data", reg_wr_data, rst ? 32'd0 : expD);
`endif
    end
    @(posedge clk);
    if (rst) begin
      modelQ.delete();
      outRegW = 1'b0; outRegA = 5'd0; outRegD = 32'd0;
    end else begin
      if (mv && ma != 5'd0) begin
        foreach (modelQ[i]) if (modelQ[i][36:32] != ma) kept.push_back(modelQ[i]);
        modelQ = kept;
      end
      if (!mv && modelQ.size() > 0) void'(modelQ.pop_front());
      if (accept && !bypass && aa != 5'd0) modelQ.push_back({aa, ad});
      outRegW = expW; outRegA = expA; outRegD = expD;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b1);
    idle(2);
    // bypass
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(2);
    // conflict
    applyStimulus(1'b0, 1'b1, 5'd4, 32'hBB, 1'b1, 5'd3, 32'hAA, 1'b1);
    idle(3);
    // backpressure: third ALU input must be ignored
    applyStimulus(1'b0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd1, 32'h1, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd11, 32'hA1, 1'b1, 5'd2, 32'h2, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd12, 32'hA2, 1'b1, 5'd3, 32'h3, 1'b1);
    idle(4);
    // WAW kill
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd9, 32'h9, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h2, 1'b1);
    idle(3);
    // register 0 handling
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h33, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5, 1'b1);
    idle(3);
    // reset with a full FIFO
    applyStimulus(1'b0, 1'b1, 5'd8, 32'h80, 1'b1, 5'd1, 32'h1, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h90, 1'b1, 5'd2, 32'h2, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd13, 32'hD0, 1'b1, 5'd4, 32'h4, 1'b1);
    idle(3);
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                    $urandom, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom, 1'b1);
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
